// File: rtl/piho_host_ctrl.sv
// piho_host_ctrl: host-side sequencer for the PIHO MCMC core.
// Decodes a byte command stream into seed/MCNconf/MCNdump loads and run
// requests, pulses the core reset, waits for finish, captures the result
// words and returns them as a framed byte stream.
// Optional build macro: PIHO_HOST_CHAIN_SUMS_EN adds x2sum1..x2sum4 to the
// OK frame (45 bytes, header 0xA6); without it the frame is 13 bytes, 0xA5.

module piho_host_ctrl #(
  parameter logic [119:0] DEF_SEED     = 120'h1234FF00EE_FF01234990_99FAAAB778,
  parameter logic [31:0]  DEF_CONF     = 32'd3,
  parameter logic [31:0]  DEF_DUMP     = 32'd2,
  parameter int unsigned  CORE_RST_CYC = 8,
  parameter logic [31:0]  TIMEOUT_CYC  = 32'd16777216
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         core_rst,
  output logic [119:0] seed,
  output logic [31:0]  MCNconf,
  output logic [31:0]  MCNdump,
  input  logic [31:0]  looptimes,
  input  logic [63:0]  x2sum1,
  input  logic [63:0]  x2sum2,
  input  logic [63:0]  x2sum3,
  input  logic [63:0]  x2sum4,
  input  logic [63:0]  x2sumall,
  input  logic         finish,
  output logic         busy
);

`ifdef PIHO_HOST_CHAIN_SUMS_EN
  localparam int         FRAME_BYTES = 45;
  localparam logic [7:0] OK_HDR      = 8'hA6;
`else
  localparam int         FRAME_BYTES = 13;
  localparam logic [7:0] OK_HDR      = 8'hA5;
`endif
  localparam int          FRAME_W   = FRAME_BYTES * 8;
  localparam logic [31:0] CRST_LAST = 32'(CORE_RST_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CRST, WAIT, SEND} state_t;
  typedef enum logic [1:0] {TGT_SEED, TGT_CONF, TGT_DUMP} tgt_t;

  state_t         state_q, state_d;
  tgt_t           tgt_q, tgt_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [5:0]     len_q, len_d;
  logic [31:0]    tmo_q, tmo_d;
  logic [111:0]   stage_q, stage_d;
  logic [119:0]   seed_q, seed_d;
  logic [31:0]    conf_q, conf_d;
  logic [31:0]    dump_q, dump_d;
  logic [7:0]     hdr_q, hdr_d;
  logic [31:0]    cap_loop_q, cap_loop_d;
  logic [63:0]    cap_all_q, cap_all_d;
  logic           rx_ready_q, rx_ready_d;
  logic           tx_valid_q, tx_valid_d;
  logic           core_rst_q, core_rst_d;
  logic           rx_fire, tx_fire;
  logic [5:0]     load_last;
  logic [FRAME_W-1:0] frame;
  logic [7:0]     tx_byte;

`ifdef PIHO_HOST_CHAIN_SUMS_EN
  logic [63:0] cap_s1_q, cap_s1_d, cap_s2_q, cap_s2_d;
  logic [63:0] cap_s3_q, cap_s3_d, cap_s4_q, cap_s4_d;
  assign frame = {hdr_q, cap_loop_q, cap_all_q, cap_s1_q, cap_s2_q, cap_s3_q, cap_s4_q};
`else
  logic unused_chain_sums;
  assign unused_chain_sums = ^{x2sum1, x2sum2, x2sum3, x2sum4};
  assign frame = {hdr_q, cap_loop_q, cap_all_q};
`endif

  assign rx_fire   = rx_valid & rx_ready_q;
  assign tx_fire   = tx_valid_q & tx_ready;
  assign load_last = (tgt_q == TGT_SEED) ? 6'd14 : 6'd3;

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign core_rst = core_rst_q;
  assign seed     = seed_q;
  assign MCNconf  = conf_q;
  assign MCNdump  = dump_q;
  assign busy     = (state_q != IDLE);
  assign tx_data  = (state_q == SEND) ? tx_byte : 8'h00;

  // Select the frame byte addressed by the send index (header is byte 0)
  always_comb begin
    tx_byte = 8'h00;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (cnt_q == 6'(i)) tx_byte = frame[(FRAME_BYTES-1-i)*8 +: 8];
    end
  end

  // Next-state, load/capture datapath and registered handshake outputs
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    stage_d    = stage_q;
    seed_d     = seed_q;
    conf_d     = conf_q;
    dump_d     = dump_q;
    hdr_d      = hdr_q;
    cap_loop_d = cap_loop_q;
    cap_all_d  = cap_all_q;
`ifdef PIHO_HOST_CHAIN_SUMS_EN
    cap_s1_d   = cap_s1_q;
    cap_s2_d   = cap_s2_q;
    cap_s3_d   = cap_s3_q;
    cap_s4_d   = cap_s4_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cnt_d = 6'd0;
          case (rx_data)
            8'h53: begin state_d = LOAD; tgt_d = TGT_SEED; end
            8'h43: begin state_d = LOAD; tgt_d = TGT_CONF; end
            8'h44: begin state_d = LOAD; tgt_d = TGT_DUMP; end
            8'h52: begin state_d = CRST; tmo_d = 32'd0; end
            8'h3F: begin state_d = SEND; hdr_d = 8'h5A; len_d = 6'd1; end
            default: begin state_d = SEND; hdr_d = 8'hEE; len_d = 6'd1; end
          endcase
        end
      end
      LOAD: begin
        if (rx_fire) begin
          stage_d = {stage_q[103:0], rx_data};
          if (cnt_q == load_last) begin
            cnt_d   = 6'd0;
            state_d = IDLE;
            case (tgt_q)
              TGT_SEED: seed_d = {stage_q, rx_data};
              TGT_CONF: conf_d = {stage_q[23:0], rx_data};
              TGT_DUMP: dump_d = {stage_q[23:0], rx_data};
              default: ;
            endcase
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      CRST: begin
        if (tmo_q == CRST_LAST) begin
          state_d = WAIT;
          tmo_d   = 32'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      WAIT: begin
        if ((tmo_q != 32'd0) && finish) begin
          cap_loop_d = looptimes;
          cap_all_d  = x2sumall;
`ifdef PIHO_HOST_CHAIN_SUMS_EN
          cap_s1_d   = x2sum1;
          cap_s2_d   = x2sum2;
          cap_s3_d   = x2sum3;
          cap_s4_d   = x2sum4;
`endif
          hdr_d   = OK_HDR;
          len_d   = 6'(FRAME_BYTES);
          cnt_d   = 6'd0;
          state_d = SEND;
        end else if (tmo_q == TIMEOUT_CYC - 32'd1) begin
          hdr_d   = 8'hE1;
          len_d   = 6'd1;
          cnt_d   = 6'd0;
          state_d = SEND;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      SEND: begin
        if (tx_fire) begin
          if (cnt_q == len_q - 6'd1) begin
            cnt_d   = 6'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rx_ready_d = (state_d == IDLE) || (state_d == LOAD);
    tx_valid_d = (state_d == SEND);
    core_rst_d = (state_d == CRST);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      tgt_q      <= TGT_SEED;
      cnt_q      <= 6'd0;
      len_q      <= 6'd0;
      tmo_q      <= 32'd0;
      stage_q    <= '0;
      seed_q     <= DEF_SEED;
      conf_q     <= DEF_CONF;
      dump_q     <= DEF_DUMP;
      hdr_q      <= 8'h00;
      cap_loop_q <= 32'd0;
      cap_all_q  <= 64'd0;
`ifdef PIHO_HOST_CHAIN_SUMS_EN
      cap_s1_q   <= 64'd0;
      cap_s2_q   <= 64'd0;
      cap_s3_q   <= 64'd0;
      cap_s4_q   <= 64'd0;
`endif
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      tmo_q      <= tmo_d;
      stage_q    <= stage_d;
      seed_q     <= seed_d;
      conf_q     <= conf_d;
      dump_q     <= dump_d;
      hdr_q      <= hdr_d;
      cap_loop_q <= cap_loop_d;
      cap_all_q  <= cap_all_d;
`ifdef PIHO_HOST_CHAIN_SUMS_EN
      cap_s1_q   <= cap_s1_d;
      cap_s2_q   <= cap_s2_d;
      cap_s3_q   <= cap_s3_d;
      cap_s4_q   <= cap_s4_d;
`endif
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      core_rst_q <= core_rst_d;
    end
  end

endmodule

// File: doc/piho_host_ctrl.md
Name: piho_host_ctrl

Overview:
- Host-side sequencer for the PIHO MCMC core (piho_top_real); it is the opposite end of that core's config/result interface.
- Accepts a byte command stream, which drives seed, MCNconf and MCNdump, a run command, and reset pulses to the core.
- Waits for the core's finish, captures its result words, and returns them as a framed byte stream.
- Sits between a UART/byte bridge and the core.

Parameters:
- DEF_SEED, 120'h1234FF00EE_FF01234990_99FAAAB778: seed register reset value.
- DEF_CONF, 32'd3: MCNconf reset value.
- DEF_DUMP, 32'd2: MCNdump reset value.
- CORE_RST_CYC, 8: number of cycles core_rst is held high per run (min 1).
- TIMEOUT_CYC, 32'd16777216: maximum cycles spent waiting for finish before an error frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- rx_data  in  8  command byte.
- rx_valid  in  1  rx_data valid; a byte is consumed when rx_valid & rx_ready.
- rx_ready  out  1  block can accept a byte.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts; a byte is transferred when tx_valid & tx_ready.
- core_rst  out  1  active-high reset to the core.
- seed  out  120  seed to the core.
- MCNconf  out  32  configuration sweep count.
- MCNdump  out  32  dump sweep count.
- looptimes  in  32  core loop counter.
- x2sum1..x2sum4  in  64 each  per-chain sums.
- x2sumall  in  64  total sum.
- finish  in  1  core done (level).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values (rst=0 at a clk edge):
  - state=IDLE, rx_ready=0, tx_valid=0, tx_data=0, busy=0.
  - core_rst=1 (core held in reset).
  - seed=DEF_SEED, MCNconf=DEF_CONF, MCNdump=DEF_DUMP.
  - Capture registers = 0.
  - rst asserted mid-operation aborts any load, run or send at once; no partial frame completes.
- First cycle after rst goes high: IDLE, rx_ready=1, core_rst=0.
- States: IDLE, LOAD, CRST, WAIT, SEND.
- IDLE (rx_ready=1), on an accepted byte:
  - 0x53 'S': LOAD, 15 bytes, target seed.
  - 0x43 'C': LOAD, 4 bytes, target MCNconf.
  - 0x44 'D': LOAD, 4 bytes, target MCNdump.
  - 0x52 'R': go to CRST.
  - 0x3F '?': SEND a 1-byte frame 0x5A (ping).
  - Any other byte: SEND a 1-byte frame 0xEE.
- LOAD (rx_ready=1):
  - Bytes are MSB first and shift into a staging register.
  - The target register updates atomically on the cycle after the last byte; until then the output keeps its old value. Then back to IDLE.
  - Byte counter wraps to 0 on exit.
- CRST:
  - core_rst=1 for exactly CORE_RST_CYC cycles, rx_ready=0.
  - Then core_rst=0, the timeout counter clears, go to WAIT.
- WAIT:
  - finish is ignored on the first WAIT cycle, which covers core reset clearing finish.
  - From the second cycle, finish=1 captures looptimes, x2sumall (and the chain sums, see optional feature) in the same cycle; then SEND with the OK frame.
  - If the counter reaches TIMEOUT_CYC first: SEND a 1-byte frame 0xE1, with captures unchanged.
- OK frame, in order:
  - 0xA5
  - looptimes, 4 bytes, MSB first
  - x2sumall, 8 bytes, MSB first
  - 13 bytes in total (base build).
- SEND:
  - tx_valid=1 with tx_data stable until tx_ready.
  - Byte index advances only on a transfer; tx_ready=0 indefinitely stalls without data loss.
  - After the last transfer, tx_valid=0 on the next cycle and the state returns to IDLE.
- rx_ready=0 in CRST, WAIT and SEND; rx bytes presented then are not consumed.
- Core outputs are not re-sampled after capture. A finish that drops and reasserts during SEND is ignored.
- rx and tx handshakes never occur in the same cycle, by construction.

Optional Feature:
- Macro: PIHO_HOST_CHAIN_SUMS_EN.
- Defined:
  - WAIT also captures x2sum1..x2sum4.
  - The OK frame appends them after x2sumall, each 8 bytes MSB first, in order 1..4.
  - Frame length is 45 bytes and the header becomes 0xA6.
- Undefined:
  - x2sum1..4 are unused (ports still present).
  - Frame is 13 bytes with header 0xA5.

Test Plan:
- Reset, then idle: seed=DEF_SEED, MCNconf=3, MCNdump=2, core_rst=1 during reset and 0 after; send '?' -> tx stream is exactly 0x5A.
- 'C',00,00,00,0A and 'D',00,00,00,05 -> MCNconf=10 and MCNdump=5, each changing only one cycle after its 4th byte.
- 'S' + 15 bytes 0x01..0x0F -> seed=120'h0102..0F; an unknown byte 0x7E -> 0xEE, with seed unchanged.
- 'R' with a core model asserting finish 100 cycles after release, looptimes=0x64, x2sumall=0x1122334455667788 -> core_rst high 8 cycles; frame A5 00 00 00 64 11 22 33 44 55 66 77 88.
- 'R' with TIMEOUT_CYC=50 and finish never asserted -> single byte 0xE1; busy falls afterwards.
- 'R' with tx_ready toggled randomly, plus rst pulsed low mid-SEND -> no byte dropped or duplicated before the pulse; after the pulse, tx_valid=0, IDLE, and registers at their defaults.
